// File: rtl/memory_access_sequencer.sv
// Sequences one data-RAM transaction per request: lane steering for writes,
// right-aligned read-back after the RAM latency, fault on misaligned/out-of-range.
//   state   | meaning
//   S_IDLE  | waiting for start; latches request and checks it
//   S_ISSUE | RAM strobe cycle (ram_en high)
//   S_WAIT  | read latency countdown, captures ram_rdata at terminal count
//   S_DONE  | done pulse, back to idle
//   S_FAULT | done + fault pulse, no RAM access
module memory_access_sequencer #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            control,
  input  logic [31:0]           Address,
  input  logic [7:0]            DataWriteByte3,
  input  logic [7:0]            DataWriteByte2,
  input  logic [7:0]            DataWriteByte1,
  input  logic [7:0]            DataWriteByte0,
  output logic [31:0]           Read,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_FAULT} state_t;

  state_t     r_state;
  logic [2:0] r_ctrl;
  logic [1:0] r_k;
  logic [1:0] r_wait;

  logic        w_is_write, w_is_read, w_is_half, w_is_word;
  logic        w_reject;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_rd_data;

  always_comb begin
    w_is_write = (control == 3'd1) || (control == 3'd2) || (control == 3'd3);
    w_is_read  = (control == 3'd4) || (control == 3'd5) || (control == 3'd6);
    w_is_half  = (control == 3'd3) || (control == 3'd5);
    w_is_word  = (control == 3'd2) || (control == 3'd6);
    // Upper address bits beyond the RAM window must be zero.
    w_reject   = (w_is_half && Address[0]) || (w_is_word && (Address[1:0] != 2'b00)) ||
                 ((Address >> (ADDR_WIDTH + 2)) != 32'd0);
    w_we       = 4'b0000;
    w_wdata    = 32'd0;
    case (control)
      3'd1: begin
        w_we    = 4'(4'b0001 << Address[1:0]);
        w_wdata = {4{DataWriteByte0}};
      end
      3'd3: begin
        w_we    = 4'(4'b0011 << Address[1:0]);
        w_wdata = {2{DataWriteByte1, DataWriteByte0}};
      end
      3'd2: begin
        w_we    = 4'b1111;
        w_wdata = {DataWriteByte3, DataWriteByte2, DataWriteByte1, DataWriteByte0};
      end
      default: ;
    endcase
    w_shifted = ram_rdata >> {r_k, 3'b000};
    case (r_ctrl)
      3'd4:    w_rd_data = {24'h0, w_shifted[7:0]};
      3'd5:    w_rd_data = {16'h0, w_shifted[15:0]};
      default: w_rd_data = w_shifted;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ctrl    <= 3'd0;
      r_k       <= 2'd0;
      r_wait    <= 2'd0;
      Read      <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 4'b0000;
      ram_addr  <= '0;
      ram_wdata <= 32'd0;
    end else begin
      done   <= 1'b0;
      fault  <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 4'b0000;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ctrl <= control;
            r_k    <= Address[1:0];
            busy   <= 1'b1;
            if (!(w_is_write || w_is_read)) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else if (w_reject) begin
              r_state <= S_FAULT;
              done    <= 1'b1;
              fault   <= 1'b1;
            end else begin
              r_state  <= S_ISSUE;
              ram_en   <= 1'b1;
              ram_we   <= w_we;
              ram_addr <= Address[ADDR_WIDTH+1:2];
              if (w_is_write) ram_wdata <= w_wdata;
            end
          end
        end
        S_ISSUE: begin
          if (r_ctrl[2]) begin
            r_state <= S_WAIT;
            r_wait  <= 2'(READ_LATENCY - 1);
          end else begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_wait == 2'd0) begin
            Read    <= w_rd_data;
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        S_DONE, S_FAULT: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
